// File: rtl/sr_pkg.sv
// Shared shift-register definitions: shift-direction constants and the
// universal-register mode encoding used by this block and the downstream stage.
package sr_pkg;

    // Shift direction selectors
    localparam bit SHIFT_LEFT  = 1'b1;
    localparam bit SHIFT_RIGHT = 1'b0;

    // Universal shift register mode encoding, shared with the downstream register
    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } sr_mode_e;

    // Pick the shift mode that moves a new bit in from the selected side
    function automatic sr_mode_e shift_mode(input bit dir);
        return (dir == SHIFT_LEFT) ? MODE_SHL : MODE_SHR;
    endfunction

endpackage

// File: rtl/mod_n_counter.sv
// Modulo-N up counter with synchronous clear and a wrap pulse that is high
// during the cycle in which an enabled increment rolls the count back to 0.
module mod_n_counter #(
    parameter int unsigned N = 4
) (
    input  logic                 CLK,
    input  logic                 Clr,
    input  logic                 clear,
    input  logic                 en,
    output logic [$clog2(N)-1:0] count,
    output logic                 wrap
);

    localparam int unsigned CntW = $clog2(N);
    localparam logic [CntW-1:0] LastCount = CntW'(N - 1);

    logic [CntW-1:0] count_q;
    logic [CntW-1:0] count_d;

    // Wrap only on a real increment; a clear on the same edge wins
    assign wrap = en && !clear && (count_q == LastCount);

    // Next count: clear > increment-with-wrap > hold
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en) begin
            count_d = wrap ? '0 : count_q + CntW'(1);
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge CLK) begin
        if (Clr) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/sipo_word_assembler.sv
// Serial-in, parallel-out word assembler. Bits are shifted into an assembly
// register; each completed word is pushed into a one-word holding register
// presented on a valid/ready handshake so the next word can assemble meanwhile.
module sipo_word_assembler
    import sr_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             Clr,
    input  logic             ser_in,
    input  logic             ser_valid,
    input  logic             frame_rst,
    input  logic             word_ready,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    output logic             busy,
    output logic             overrun
);

    localparam int unsigned CntW     = $clog2(WIDTH);
    localparam bit          ShiftDir = MSB_FIRST ? SHIFT_LEFT : SHIFT_RIGHT;

    logic [CntW-1:0]  bit_cnt;
    logic             word_done;

    sr_mode_e         asm_mode;
    logic [WIDTH-1:0] asm_q;
    logic [WIDTH-1:0] asm_d;

    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] word_d;
    logic             valid_q;
    logic             valid_d;
    logic             overrun_q;
    logic             overrun_d;

    logic             hold_load;
    logic             hold_drop;

    mod_n_counter #(
        .N(WIDTH)
    ) u_bit_cnt (
        .CLK  (CLK),
        .Clr  (Clr),
        .clear(frame_rst),
        .en   (ser_valid),
        .count(bit_cnt),
        .wrap (word_done)
    );

    // Assembly register operates as a universal register: abort loads zero,
    // a valid bit shifts in from the configured side, otherwise hold
    always_comb begin
        asm_mode = MODE_HOLD;
        if (frame_rst) begin
            asm_mode = MODE_LOAD;
        end else if (ser_valid) begin
            asm_mode = shift_mode(ShiftDir);
        end
    end

    // Next assembly contents for the selected mode
    always_comb begin
        asm_d = asm_q;
        unique case (asm_mode)
            MODE_HOLD: asm_d = asm_q;
            MODE_SHL:  asm_d = {asm_q[WIDTH-2:0], ser_in};
            MODE_SHR:  asm_d = {ser_in, asm_q[WIDTH-1:1]};
            MODE_LOAD: asm_d = '0;
            default:   asm_d = asm_q;
        endcase
    end

    // A completed word goes into the holding register if it is empty or being
    // drained this edge; otherwise it is lost and the old word is kept stable
    assign hold_load = word_done && (!valid_q || word_ready);
    assign hold_drop = word_done && valid_q && !word_ready;

    // Holding register and sticky overrun next-state
    always_comb begin
        word_d    = word_q;
        valid_d   = valid_q;
        overrun_d = overrun_q | hold_drop;
        if (hold_load) begin
            // asm_d already includes the bit captured on this edge
            word_d  = asm_d;
            valid_d = 1'b1;
        end else if (valid_q && word_ready) begin
            valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (Clr) begin
            asm_q     <= '0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            asm_q     <= asm_d;
            word_q    <= word_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign word_out   = word_q;
    assign word_valid = valid_q;
    assign overrun    = overrun_q;
    assign busy       = (bit_cnt != '0);

endmodule

// File: tb/tb_sipo_word_assembler.sv
// Directed bench for sipo_word_assembler: one MSB-first and one LSB-first
// instance driven by the same stimulus, checked against hand-computed values.
module tb_sipo_word_assembler;

    localparam int unsigned W = 4;

    logic         CLK = 1'b0;
    logic         Clr;
    logic         ser_in;
    logic         ser_valid;
    logic         frame_rst;
    logic         word_ready;

    logic [W-1:0] m_word, l_word;
    logic         m_valid, l_valid;
    logic         m_busy, l_busy;
    logic         m_ovr, l_ovr;

    int unsigned  n_vec = 0;
    int unsigned  n_err = 0;

    always #5 CLK = ~CLK;

    sipo_word_assembler #(
        .WIDTH    (W),
        .MSB_FIRST(1'b1)
    ) dut_msb (
        .CLK       (CLK),
        .Clr       (Clr),
        .ser_in    (ser_in),
        .ser_valid (ser_valid),
        .frame_rst (frame_rst),
        .word_ready(word_ready),
        .word_out  (m_word),
        .word_valid(m_valid),
        .busy      (m_busy),
        .overrun   (m_ovr)
    );

    sipo_word_assembler #(
        .WIDTH    (W),
        .MSB_FIRST(1'b0)
    ) dut_lsb (
        .CLK       (CLK),
        .Clr       (Clr),
        .ser_in    (ser_in),
        .ser_valid (ser_valid),
        .frame_rst (frame_rst),
        .word_ready(word_ready),
        .word_out  (l_word),
        .word_valid(l_valid),
        .busy      (l_busy),
        .overrun   (l_ovr)
    );

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 time unit after it
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ser_valid = 1'b1;
        ser_in    = b;
        step();
        ser_valid = 1'b0;
        ser_in    = 1'b0;
    endtask

    task automatic send_word(input logic [3:0] w);
        for (int i = 3; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        Clr = 1'b1; ser_in = 1'b0; ser_valid = 1'b0; frame_rst = 1'b0; word_ready = 1'b1;
        step();
        step();
        Clr = 1'b0;
        check_eq("rst_word", m_word, 4'h0);
        check_eq("rst_valid", m_valid, 1'b0);
        check_eq("rst_busy", m_busy, 1'b0);
        check_eq("rst_ovr", m_ovr, 1'b0);

        // 1/2: bits 1,0,1,1 back to back, ready high
        send_bit(1'b1);
        check_eq("t1_busy1", m_busy, 1'b1);
        send_bit(1'b0);
        check_eq("t1_busy2", m_busy, 1'b1);
        send_bit(1'b1);
        check_eq("t1_busy3", m_busy, 1'b1);
        check_eq("t1_novalid", m_valid, 1'b0);
        send_bit(1'b1);
        check_eq("t1_word", m_word, 4'b1011);
        check_eq("t1_valid", m_valid, 1'b1);
        check_eq("t1_busy4", m_busy, 1'b0);
        check_eq("t2_word", l_word, 4'b1101);
        check_eq("t2_valid", l_valid, 1'b1);
        step();
        check_eq("t1_valid_1cyc", m_valid, 1'b0);
        check_eq("t1_word_hold", m_word, 4'b1011);

        // 3: ready low, second word overruns
        word_ready = 1'b0;
        send_word(4'b1011);
        check_eq("t3_valid", m_valid, 1'b1);
        send_word(4'b0110);
        check_eq("t3_word_kept", m_word, 4'b1011);
        check_eq("t3_ovr", m_ovr, 1'b1);
        check_eq("t3_ovr_lsb", l_ovr, 1'b1);
        check_eq("t3_word_lsb", l_word, 4'b1101);
        word_ready = 1'b1;
        step();
        check_eq("t3_drain", m_valid, 1'b0);
        check_eq("t3_ovr_sticky", m_ovr, 1'b1);

        // 4: accept and reload on the same edge
        Clr = 1'b1;
        step();
        Clr = 1'b0;
        word_ready = 1'b0;
        send_word(4'b1011);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        check_eq("t4_pre_word", m_word, 4'b1011);
        word_ready = 1'b1;
        send_bit(1'b0);
        check_eq("t4_word", m_word, 4'b0110);
        check_eq("t4_valid", m_valid, 1'b1);
        check_eq("t4_ovr", m_ovr, 1'b0);
        step();
        check_eq("t4_drain", m_valid, 1'b0);

        // 5: frame abort with a valid bit, then bits with idle gaps
        send_bit(1'b1);
        send_bit(1'b1);
        frame_rst = 1'b1;
        send_bit(1'b1);
        frame_rst = 1'b0;
        check_eq("t5_abort_busy", m_busy, 1'b0);
        check_eq("t5_abort_valid", m_valid, 1'b0);
        send_bit(1'b0);
        idle(2);
        send_bit(1'b1);
        idle(1);
        send_bit(1'b0);
        idle(3);
        check_eq("t5_gap_busy", m_busy, 1'b1);
        check_eq("t5_gap_valid", m_valid, 1'b0);
        send_bit(1'b1);
        check_eq("t5_word", m_word, 4'b0101);
        check_eq("t5_valid", m_valid, 1'b1);
        check_eq("t5_word_lsb", l_word, 4'b1010);
        step();
        check_eq("t5_no_extra", m_valid, 1'b0);

        // 6: abort leaves holding register alone; Clr mid-frame clears all
        word_ready = 1'b0;
        send_word(4'b1011);
        send_word(4'b0110);
        send_bit(1'b1);
        frame_rst = 1'b1;
        step();
        frame_rst = 1'b0;
        check_eq("t6_fr_valid", m_valid, 1'b1);
        check_eq("t6_fr_ovr", m_ovr, 1'b1);
        check_eq("t6_fr_busy", m_busy, 1'b0);
        check_eq("t6_fr_word", m_word, 4'b1011);
        send_bit(1'b1);
        send_bit(1'b1);
        check_eq("t6_busy", m_busy, 1'b1);
        Clr = 1'b1;
        ser_valid = 1'b1;
        ser_in = 1'b1;
        step();
        Clr = 1'b0;
        ser_valid = 1'b0;
        check_eq("t6_clr_word", m_word, 4'h0);
        check_eq("t6_clr_valid", m_valid, 1'b0);
        check_eq("t6_clr_busy", m_busy, 1'b0);
        check_eq("t6_clr_ovr", m_ovr, 1'b0);
        send_word(4'b1110);
        check_eq("t6_word", m_word, 4'b1110);
        check_eq("t6_valid", m_valid, 1'b1);
        check_eq("t6_word_lsb", l_word, 4'b0111);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sipo_word_assembler.md
Name: sipo_word_assembler

Overview:
- Serial-in, parallel-out front end that collects a serial bit stream into WIDTH-bit words.
- Each completed word is presented downstream on a valid/ready handshake, sized to drive the parallel-load input of the team's universal shift register or counter stage.
- Internals: an assembly shift register, a mod-WIDTH bit counter, and a one-word holding register, so the next word can assemble while the current one waits.

Parameters:
- WIDTH, 4, word length in bits; legal range 2..16.
- MSB_FIRST, 1, 1 = first received bit lands in word_out[WIDTH-1] (left shift); 0 = first bit lands in word_out[0] (right shift).

Ports:
- CLK  in  1  single clock; all state updates on posedge.
- Clr  in  1  reset; synchronous, active-high; clears all state.
- ser_in  in  1  serial data bit.
- ser_valid  in  1  ser_in is sampled on this edge when high.
- frame_rst  in  1  synchronous abort of the partial word currently assembling.
- word_ready  in  1  downstream accepts word_out when high together with word_valid.
- word_out  out  WIDTH  assembled word from the holding register.
- word_valid  out  1  holding register contains an unaccepted word.
- busy  out  1  partial word in progress (bit count != 0).
- overrun  out  1  sticky flag: a completed word was dropped.

Behaviour:
- Reset (Clr=1 at an edge): assembly register=0, bit count=0, word_out=0, word_valid=0, busy=0, overrun=0. Clr overrides every other input. Clr asserted mid-frame discards the partial word.
- Priority each edge: Clr > frame_rst > bit capture.
- Capture (ser_valid=1, frame_rst=0):
  - MSB_FIRST=1: asm <= {asm[WIDTH-2:0], ser_in}.
  - MSB_FIRST=0: asm <= {ser_in, asm[WIDTH-1:1]}.
  - Count increments modulo WIDTH.
  - ser_valid=0: no change; gaps of any length are allowed.
- Completion: capture while count==WIDTH-1.
  - The assembled word, including the current bit, is the completed word. Count wraps to 0.
  - Zero added latency: word_out/word_valid update on that same edge.
- Holding register on a completion edge:
  - word_valid=0, or word_valid=1 and word_ready=1: load the completed word, word_valid=1. A simultaneous accept and reload leaves word_valid high with no bubble.
  - word_valid=1 and word_ready=0: completed word dropped, old word held, overrun<=1.
- Holding register on a non-completion edge: word_valid=1 and word_ready=1 clears word_valid; word_out holds its last value.
- frame_rst=1: count<=0, asm<=0, incoming bit discarded. Holding register, word_valid and overrun are unaffected.
- overrun is cleared only by Clr.
- busy is a combinational decode of count != 0.
- Count width is $clog2(WIDTH). No arithmetic beyond the counter increment.
- word_out must not change while word_valid=1 and word_ready=0.

Decomposition:
- Shared package sr_pkg:
  - Shift-direction constants SHIFT_LEFT/SHIFT_RIGHT.
  - Universal-register mode encodings MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11, shared with the downstream register.
- One sub-module: mod_n_counter, with parameter N, ports CLK, Clr, clear, en, count, wrap. It provides the bit counter and its wrap/completion pulse.

Test Plan:
1. WIDTH=4, MSB_FIRST=1, word_ready=1; bits 1,0,1,1 on consecutive cycles -> after the 4th edge word_out=4'b1011, word_valid=1 for exactly one cycle, busy high for 3 cycles.
2. MSB_FIRST=0, same stimulus -> word_out=4'b1101, word_valid=1 after the 4th edge.
3. word_ready=0; send 1011 then 0110 -> word_out stays 4'b1011, overrun=1 after the 8th bit. Then word_ready=1 -> word_valid drops next edge, overrun stays 1.
4. word_valid=1 holding 1011, word_ready=1 on the edge that completes 0110 -> word_out=4'b0110, word_valid stays 1, overrun=0.
5. Bits 1,1 then frame_rst=1 with ser_valid=1, then 0,1,0,1 with idle ser_valid gaps between bits -> word_out=4'b0101 (MSB_FIRST=1), no extra word.
6. Clr=1 after 2 of 4 bits, with word_valid=1 and overrun=1 -> next edge all outputs 0. The following 4 bits 1,1,1,0 produce 4'b1110.
